dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single data-memory port between two requesters: the core's load/store path (requester 0) and the host/debug access path (requester 1). Core has fixed priority, host has a starvation guard, and the block issues one access per cycle. A read-tag pipeline returns each read response to its owner. It also drives the sideband (load flag, byte offset, funct3) that the load unit needs, aligned with the returned memory word. It sits between the execute/memory stage, the host bridge, the data BRAM and the load unit.

## Interface
- RD_LATENCY, 1: memory read latency in cycles, i_mem_rdata valid this many cycles after o_mem_en; legal 1..4.
- ADDR_W, 12: word-address width of the data memory.
- HOST_MAX_WAIT, 4: consecutive cycles host may be refused before it is forced through; legal 1..15.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_core_req / i_host_req  in  1  access request, held until granted.
- i_core_we / i_host_we  in  1  1 = store, 0 = load.
- i_core_addr / i_host_addr  in  ADDR_W+2  byte address.
- i_core_wdata / i_host_wdata  in  32  store data, already lane-aligned.
- i_core_be / i_host_be  in  4  store byte enables.
- i_core_funct3  in  3  load funct3; the host always reads full words and uses funct3 = 3'b010.
- o_core_gnt / o_host_gnt  out  1  request accepted this cycle; combinational.
- o_core_rvalid / o_host_rvalid  out  1  read data for this requester on o_rdata.
- o_rdata  out  32  i_mem_rdata passed through.
- o_lu_load  out  1  core load response this cycle; drives the load unit i_load.
- o_lu_addr  out  2  byte offset of that load.
- o_lu_funct3  out  3  funct3 of that load.
- o_mem_en  out  1  memory access enable.
- o_mem_we  out  4  per-byte write enable; 0 for reads.
- o_mem_addr  out  ADDR_W  word address, i.e. byte address [ADDR_W+1:2].
- o_mem_wdata  out  32  write data.
- i_mem_rdata  in  32  memory read data.

## Operation
- Winner selection:
  - The host wins if i_host_req and either i_core_req = 0 or wait_cnt = HOST_MAX_WAIT.
  - Otherwise the core wins if i_core_req.
- Exactly one grant per cycle at most. o_mem_* carry the winner's fields. With no winner, o_mem_en = 0, o_mem_we = 0, and addr/wdata are don't-care.
- o_mem_we = winner be when we = 1, otherwise 0.
- wait_cnt, 4 bits:
  - cleared on any host grant or when i_host_req = 0;
  - incremented when i_host_req = 1 and the core is granted;
  - saturates at HOST_MAX_WAIT.
- Read-tag pipeline: RD_LATENCY stages, each holding {valid, id, addr[1:0], funct3}.
  - Stage 0 loads valid = (grant & ~we) together with the winner's tag.
  - The pipeline shifts every cycle; it is never stalled.
- Last stage drives the outputs:
  - valid & id = 0 gives o_core_rvalid = 1 and o_lu_load = 1, with o_lu_addr/o_lu_funct3 taken from the tag.
  - valid & id = 1 gives o_host_rvalid = 1 and o_lu_load = 0.
- Writes produce no response. A write and a read of the same address in consecutive cycles are ordered by memory port order; the arbiter adds no forwarding.
- Reset, asynchronous on rst_n low: all tag-stage valids = 0 and wait_cnt = 0.
  - Consequently o_core_rvalid, o_host_rvalid and o_lu_load are 0, and o_lu_addr = 0, o_lu_funct3 = 0.
  - Grants and o_mem_* follow the inputs combinationally, but are forced to 0 while rst_n is low.
  - Reads in flight at reset are dropped, with no response.

## Timing
- Grant and o_mem_en assert in the same cycle T as the request.
- Read response appears at T+RD_LATENCY, together with i_mem_rdata.
- Throughput: one access per cycle. Back-to-back reads from alternating requesters return in issue order.
- Load unit sideband: o_lu_* is aligned with o_rdata. The load unit's own pipe stages add latency downstream of this block.
- Worst-case host wait with the core requesting continuously: HOST_MAX_WAIT cycles refused, then granted on the next cycle.

## Test plan
- Reset with reads in flight: rst_n low for 1 cycle while RD_LATENCY=2 and two reads are pending. All rvalid stay 0 afterwards, and wait_cnt = 0.
- Core only, RD_LATENCY=1: core LB to byte addr 0x0003, then LHU to 0x0006.
  - Request cycles: o_mem_addr = 0x000 then 0x001.
  - Responses: o_core_rvalid and o_lu_load in the next cycles, with o_lu_addr = 3 / funct3 = 000, then addr = 2 / funct3 = 101.
- Host starvation, HOST_MAX_WAIT=4: core and host request continuously.
  - Grant pattern: core ×4, host ×1, core ×4, host ×1.
  - o_host_gnt is never asserted on two consecutive cycles while the core is requesting.
- Simultaneous: core read and host read issued in the same cycle with wait_cnt = 0. The core is granted; the host is granted the next cycle once the core drops its request. With RD_LATENCY=3, the responses arrive on consecutive cycles, core first.
- Store: core store to addr 0x0008 with be = 4'b0100 and wdata = 0x00AB0000 gives o_mem_we = 4'b0100 and o_mem_addr = 0x002. No rvalid follows.
- Host idle: i_host_req = 0 for all cycles, so wait_cnt stays 0 and the core is granted every requesting cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core has priority, host has a starvation guard.
// Read tags ride alongside the memory latency to steer responses and load sideband.
module dmem_port_arbiter #(
  parameter int RD_LATENCY    = 1,
  parameter int ADDR_W        = 12,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W+1:0] i_core_addr,
  input  logic [31:0]       i_core_wdata,
  input  logic [3:0]        i_core_be,
  input  logic [2:0]        i_core_funct3,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W+1:0] i_host_addr,
  input  logic [31:0]       i_host_wdata,
  input  logic [3:0]        i_host_be,
  output logic              o_core_gnt,
  output logic              o_host_gnt,
  output logic              o_core_rvalid,
  output logic              o_host_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_lu_load,
  output logic [1:0]        o_lu_addr,
  output logic [2:0]        o_lu_funct3,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef struct packed {
    logic       v;
    logic       id;
    logic [1:0] a;
    logic [2:0] f3;
  } tag_t;

  localparam logic [3:0] MAX_W = 4'(HOST_MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       host_win;
  logic       core_win;
  tag_t       tag_in;
  tag_t       tag_out;
  tag_t       pipe [RD_LATENCY];

  assign host_win = rst_n & i_host_req
                  & (~i_core_req | (wait_cnt == MAX_W));
  assign core_win = rst_n & i_core_req & ~host_win;

  assign o_core_gnt = core_win;
  assign o_host_gnt = host_win;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 4'b0;
    o_mem_addr  = i_core_addr[ADDR_W+1:2];
    o_mem_wdata = i_core_wdata;
    tag_in      = '0;
    unique case (1'b1)
      host_win: begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_host_we ? i_host_be : 4'b0;
        o_mem_addr  = i_host_addr[ADDR_W+1:2];
        o_mem_wdata = i_host_wdata;
        tag_in.v    = ~i_host_we;
        tag_in.id   = 1'b1;
        tag_in.a    = i_host_addr[1:0];
        tag_in.f3   = 3'b010;
      end
      core_win: begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_core_we ? i_core_be : 4'b0;
        tag_in.v    = ~i_core_we;
        tag_in.id   = 1'b0;
        tag_in.a    = i_core_addr[1:0];
        tag_in.f3   = i_core_funct3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (!i_host_req || host_win) begin
      wait_cnt <= 4'd0;
    end else if (core_win && wait_cnt != MAX_W) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // never stalls: memory returns data a fixed number of cycles later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out       = pipe[RD_LATENCY-1];
  assign o_core_rvalid = tag_out.v & ~tag_out.id;
  assign o_host_rvalid = tag_out.v & tag_out.id;
  assign o_lu_load     = o_core_rvalid;
  assign o_lu_addr     = o_core_rvalid ? tag_out.a : 2'b0;
  assign o_lu_funct3   = o_core_rvalid ? tag_out.f3 : 3'b0;
  assign o_rdata       = i_mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized + directed bench for dmem_port_arbiter.
// Scoreboard queue of expected read responses, compared by a negedge monitor.
module tb_dmem_port_arbiter;
  localparam int L   = 2;
  localparam int AW  = 12;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic i_core_req = 0, i_core_we = 0, i_host_req = 0, i_host_we = 0;
  logic [AW+1:0] i_core_addr = '0, i_host_addr = '0;
  logic [31:0] i_core_wdata = '0, i_host_wdata = '0;
  logic [3:0] i_core_be = '0, i_host_be = '0;
  logic [2:0] i_core_funct3 = '0;
  logic o_core_gnt, o_host_gnt, o_core_rvalid, o_host_rvalid;
  logic [31:0] o_rdata, o_mem_wdata, i_mem_rdata;
  logic o_lu_load, o_mem_en;
  logic [1:0] o_lu_addr;
  logic [2:0] o_lu_funct3;
  logic [3:0] o_mem_we;
  logic [AW-1:0] o_mem_addr;

  dmem_port_arbiter #(.RD_LATENCY(L), .ADDR_W(AW), .HOST_MAX_WAIT(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_core_req(i_core_req), .i_core_we(i_core_we),
    .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata),
    .i_core_be(i_core_be), .i_core_funct3(i_core_funct3),
    .i_host_req(i_host_req), .i_host_we(i_host_we),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
    .i_host_be(i_host_be),
    .o_core_gnt(o_core_gnt), .o_host_gnt(o_host_gnt),
    .o_core_rvalid(o_core_rvalid), .o_host_rvalid(o_host_rvalid),
    .o_rdata(o_rdata), .o_lu_load(o_lu_load),
    .o_lu_addr(o_lu_addr), .o_lu_funct3(o_lu_funct3),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_of(input int c);
    return (32'(c) * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  assign i_mem_rdata = rd_of(cyc);

  typedef struct {
    int          due;
    bit          id;
    bit [1:0]    a;
    bit [2:0]    f3;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  int wcnt = 0;
  bit c_g = 0, h_g = 0, prev_h = 0;
  int hcount = 0, ccount = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // monitor: responses against the queue, grants against the priority rules
  always @(negedge clk) begin
    exp_t e;
    bit hw, cw, we;
    logic [AW+1:0] a;
    logic [3:0] be;
    logic [2:0] f3;
    logic [31:0] wd;
    if (!rst_n) begin
      chk("reset_outputs",
          {o_core_gnt, o_host_gnt, o_mem_en, o_mem_we, o_core_rvalid,
           o_host_rvalid, o_lu_load, o_lu_addr, o_lu_funct3}, 64'd0);
      exp_q.delete();
      wcnt = 0; c_g = 0; h_g = 0; prev_h = 0;
    end else begin
      if (o_core_rvalid || o_host_rvalid) begin
        if (exp_q.size() == 0) chk("spurious_rvalid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          chk("rsp_owner", {o_core_rvalid, o_host_rvalid},
              e.id ? 2'b01 : 2'b10);
          chk("rsp_rdata", o_rdata, e.d);
          chk("rsp_lu_load", o_lu_load, !e.id);
          if (!e.id)
            chk("rsp_lu_side", {o_lu_addr, o_lu_funct3}, {e.a, e.f3});
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("missing_rsp", 0, 1);
        void'(exp_q.pop_front());
      end else begin
        chk("idle_lu_load", o_lu_load, 0);
      end

      hw = i_host_req && (!i_core_req || wcnt == MAX);
      cw = !hw && i_core_req;
      chk("grant", {o_core_gnt, o_host_gnt}, {cw, hw});
      if (cw || hw) begin
        we = hw ? i_host_we : i_core_we;
        a  = hw ? i_host_addr : i_core_addr;
        be = hw ? i_host_be : i_core_be;
        wd = hw ? i_host_wdata : i_core_wdata;
        f3 = hw ? 3'b010 : i_core_funct3;
        chk("mem_en", o_mem_en, 1);
        chk("mem_we", o_mem_we, we ? be : 4'b0);
        chk("mem_addr", o_mem_addr, a[AW+1:2]);
        if (we) chk("mem_wdata", o_mem_wdata, wd);
        else exp_q.push_back('{cyc + L, hw, a[1:0], f3, rd_of(cyc + L)});
      end else begin
        chk("mem_idle", {o_mem_en, o_mem_we}, 0);
      end
      if (o_host_gnt && i_core_req) chk("host_back_to_back", prev_h, 0);

      if (!i_host_req || hw) wcnt = 0;
      else if (cw && wcnt < MAX) wcnt++;
      c_g = o_core_gnt;
      h_g = o_host_gnt;
      prev_h = o_host_gnt;
      if (o_host_gnt) hcount++;
      if (o_core_gnt) ccount++;
    end
  end

  task automatic core_op(input bit we, input logic [AW+1:0] a,
                         input logic [2:0] f3, input logic [3:0] be,
                         input logic [31:0] wd);
    i_core_req = 1; i_core_we = we; i_core_addr = a;
    i_core_funct3 = f3; i_core_be = be; i_core_wdata = wd;
    for (int n = 0; ; n++) begin
      @(posedge clk); #1;
      if (c_g) break;
      if (n == 50) begin chk("core_gnt_timeout", 0, 1); break; end
    end
    i_core_req = 0;
  endtask

  task automatic host_op(input bit we, input logic [AW+1:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    i_host_req = 1; i_host_we = we; i_host_addr = a;
    i_host_be = be; i_host_wdata = wd;
    for (int n = 0; ; n++) begin
      @(posedge clk); #1;
      if (h_g) break;
      if (n == 50) begin chk("host_gnt_timeout", 0, 1); break; end
    end
    i_host_req = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    core_op(0, 14'h0003, 3'b000, 4'h0, 32'h0);
    core_op(0, 14'h0006, 3'b101, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    core_op(1, 14'h0008, 3'b010, 4'b0100, 32'h00AB0000);
    repeat (3) @(posedge clk);
    #1;

    fork
      core_op(0, 14'h0101, 3'b100, 4'h0, 32'h0);
      host_op(0, 14'h0202, 4'h0, 32'h0);
    join
    repeat (3) @(posedge clk);
    #1;

    fork
      core_op(0, 14'h0015, 3'b001, 4'h0, 32'h0);
      host_op(0, 14'h0020, 4'h0, 32'h0);
    join
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;

    for (int k = 0; k < 30; k++) begin
      i_core_req = 1;
      i_core_we = 1'($urandom_range(0, 1));
      i_core_addr = 14'($urandom);
      i_core_funct3 = 3'($urandom);
      i_core_be = 4'($urandom);
      i_core_wdata = $urandom;
      @(posedge clk); #1;
    end
    i_core_req = 0;
    @(posedge clk); #1;

    hcount = 0; ccount = 0;
    i_core_req = 1; i_core_we = 0; i_core_addr = 14'h0040;
    i_host_req = 1; i_host_we = 0; i_host_addr = 14'h0080;
    repeat (20) @(posedge clk);
    #1;
    i_core_req = 0; i_host_req = 0;
    chk("starve_host_grants", 64'(hcount), 64'd4);
    chk("starve_core_grants", 64'(ccount), 64'd16);
    repeat (4) @(posedge clk);
    #1;

    for (int k = 0; k < 400; k++) begin
      if (!i_core_req || c_g) begin
        i_core_req = ($urandom_range(0, 9) < 6);
        i_core_we = 1'($urandom_range(0, 1));
        i_core_addr = 14'($urandom);
        i_core_funct3 = 3'($urandom);
        i_core_be = 4'($urandom);
        i_core_wdata = $urandom;
      end
      if (!i_host_req || h_g) begin
        i_host_req = ($urandom_range(0, 9) < 5);
        i_host_we = 1'($urandom_range(0, 1));
        i_host_addr = 14'($urandom);
        i_host_be = 4'($urandom);
        i_host_wdata = $urandom;
      end
      @(posedge clk); #1;
    end
    i_core_req = 0; i_host_req = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
